sasa_match_drain: RTL and testbench

Parametrised multi-match resolver for the SASA CAM. It accepts one match vector and emits every set bit, one beat per cycle, as a one-hot vector plus binary index. Scan order is selectable per request (MSB-first, matching the legacy highest-match rule, or LSB-first), and an optional hit limit can stop the scan early. It sits between the CAM match-line register and the downstream entry-read logic, and replaces the single-shot highest-match selection wherever all hits must be serviced.

---
 rtl/sasa_match_drain.sv | 167 ++++++++++++++++
 tb/tb_sasa_match_drain.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sasa_match_drain.sv
// sasa_match_drain
//
// Multi-match resolver for the SASA CAM. A request carries one OR'd match
// vector; the block then emits every set bit as a separate beat, one beat per
// cycle, until the vector is empty or the optional hit limit is reached.
// Scan order is chosen per request: highest index first (the legacy
// highest-match rule) or lowest index first.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   in_valid     : request valid
//   in_ready     : block idle and able to take a request (0 while rst high)
//   in_vector    : match vector to drain
//   in_lsb_first : 0 = highest index first, 1 = lowest index first
//   in_limit     : maximum beats to emit, 0 = unlimited
//   out_valid    : result beat valid
//   out_ready    : consumer accepts the beat
//   out_hit      : beat carries a real match (0 only on the empty-vector beat)
//   out_onehot   : one-hot position of the current match
//   out_index    : binary index of the current match
//   out_last     : final beat of the request
//   out_trunc    : with out_last, the limit stopped the scan early
//   out_count    : 1-based number of the current beat
module sasa_match_drain #(
  parameter int CAM_LEN = 256,
  parameter int IDX_W   = $clog2(CAM_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CAM_LEN-1:0] in_vector,
  input  logic               in_lsb_first,
  input  logic [IDX_W:0]     in_limit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_hit,
  output logic [CAM_LEN-1:0] out_onehot,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               out_trunc,
  output logic [IDX_W:0]     out_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CAM_LEN-1:0] VEC_ZERO = {CAM_LEN{1'b0}};
  localparam logic [CAM_LEN-1:0] VEC_ONE  = {{(CAM_LEN-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]     CNT_ZERO = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]     CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  state_t               stateR;
  state_t               stateNextS;
  logic [CAM_LEN-1:0]   remR;
  logic [IDX_W:0]       cntR;
  logic [IDX_W:0]       limitR;
  logic                 dirR;

  logic [CAM_LEN-1:0]   pickS;
  logic [CAM_LEN-1:0]   restS;
  logic [IDX_W:0]       cntIncS;
  logic                 scanS;
  logic                 limitHitS;
  logic                 acceptS;
  logic                 beatDoneS;

  // Mirror a vector so the lowest-bit isolate can also serve MSB-first order.
  function automatic logic [CAM_LEN-1:0] bitReverse(input logic [CAM_LEN-1:0] v);
    logic [CAM_LEN-1:0] r;
    for (int i = 0; i < CAM_LEN; i++) begin
      r[i] = v[CAM_LEN-1-i];
    end
    return r;
  endfunction

  // x & -x keeps only the lowest set bit; carry chain maps to a fast adder.
  function automatic logic [CAM_LEN-1:0] lowestBit(input logic [CAM_LEN-1:0] v);
    return v & ((~v) + VEC_ONE);
  endfunction

  // One-hot to binary: OR of the indices whose bit is set (input is one-hot).
  function automatic logic [IDX_W-1:0] encodeOnehot(input logic [CAM_LEN-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < CAM_LEN; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

  // Beat datapath: priority pick over the remaining matches and beat flags.
  always_comb begin
    scanS     = (stateR == SCAN);
    pickS     = dirR ? lowestBit(remR) : bitReverse(lowestBit(bitReverse(remR)));
    restS     = remR & ~pickS;
    cntIncS   = cntR + CNT_ONE;
    limitHitS = (limitR != CNT_ZERO) && (cntIncS == limitR);

    // in_ready is gated by rst directly so it reads 0 throughout reset.
    in_ready   = (stateR == IDLE) && !rst;
    out_valid  = scanS;
    out_hit    = scanS && (remR != VEC_ZERO);
    // rem can be non-zero in IDLE after a truncated scan, so mask the pick.
    out_onehot = scanS ? pickS : VEC_ZERO;
    out_index  = encodeOnehot(out_onehot);
    out_last   = scanS && ((restS == VEC_ZERO) || limitHitS);
    out_trunc  = scanS && limitHitS && (restS != VEC_ZERO);
    out_count  = cntIncS;

    acceptS    = in_valid && in_ready;
    beatDoneS  = scanS && out_ready;
  end

  // Next-state logic for the IDLE/SCAN controller.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          stateNextS = SCAN;
        end else begin
          stateNextS = IDLE;
        end
      end
      SCAN: begin
        if (beatDoneS && out_last) begin
          stateNextS = IDLE;
        end else begin
          stateNextS = SCAN;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // State register; reset drops out_valid immediately and discards the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Request registers: loaded on accept, consumed one match per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remR   <= VEC_ZERO;
      cntR   <= CNT_ZERO;
      limitR <= CNT_ZERO;
      dirR   <= 1'b0;
    end else if (acceptS) begin
      remR   <= in_vector;
      cntR   <= CNT_ZERO;
      limitR <= in_limit;
      dirR   <= in_lsb_first;
    end else if (beatDoneS) begin
      remR   <= restS;
      cntR   <= cntIncS;
    end
  end

endmodule

// File: tb/tb_sasa_match_drain.sv
// Self-checking bench for sasa_match_drain. A reference model pushes the
// expected beat sequence into a scoreboard queue when a request is driven;
// beats are popped and compared as the DUT presents them.
module tb_sasa_match_drain;

  localparam int N = 256;
  localparam int W = 8;

  typedef struct packed {
    logic         hit;
    logic [N-1:0] onehot;
    logic [W-1:0] idx;
    logic         last;
    logic         trunc;
    logic [W:0]   cnt;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vector = '0;
  logic         in_lsb_first = 1'b0;
  logic [W:0]   in_limit = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_hit;
  logic [N-1:0] out_onehot;
  logic [W-1:0] out_index;
  logic         out_last;
  logic         out_trunc;
  logic [W:0]   out_count;

  int    vectors = 0;
  int    errors  = 0;
  beat_t exp_q[$];

  sasa_match_drain #(.CAM_LEN(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
    .in_lsb_first(in_lsb_first), .in_limit(in_limit),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_onehot(out_onehot), .out_index(out_index), .out_last(out_last),
    .out_trunc(out_trunc), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Reference model: walk the vector in scan order and build every beat.
  task automatic push_expected(input logic [N-1:0] vec, input logic lsb, input logic [W:0] lim);
    int    p;
    int    n;
    int    pos;
    beat_t b;
    p = $countones(vec);
    n = 0;
    if (p == 0) begin
      b = '0;
      b.last = 1'b1;
      b.cnt  = 9'd1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < N; k++) begin
        pos = lsb ? k : N - 1 - k;
        if (vec[pos]) begin
          n++;
          b = '0;
          b.hit = 1'b1;
          b.onehot[pos] = 1'b1;
          b.idx   = pos[W-1:0];
          b.cnt   = n[W:0];
          b.trunc = (lim != 0) && (n == int'(lim)) && (n < p);
          b.last  = (n == p) || ((lim != 0) && (n == int'(lim)));
          exp_q.push_back(b);
          if (b.last) break;
        end
      end
    end
  endtask

  // Drive one request (called and returning at a falling edge).
  task automatic send(input logic [N-1:0] vec, input logic lsb, input logic [W:0] lim);
    int g = 0;
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    end
    push_expected(vec, lsb, lim);
    in_valid = 1'b1; in_vector = vec; in_lsb_first = lsb; in_limit = lim;
    @(negedge clk);
    // Garbage on the request inputs outside the accept cycle must be ignored.
    in_valid = 1'b0;
    in_vector = {8{$urandom()}};
    in_lsb_first = ~lsb;
    in_limit = 9'd1;
  endtask

  // Scoreboard consumer. mode 0: ready high, 1: ready 1-0-0-1-1..., 2: random.
  task automatic drain(input int mode);
    int    cyc = 0;
    beat_t o;
    beat_t e;
    logic  rdy;
    while (exp_q.size() > 0 && cyc < 2000) begin
      case (mode)
        1:       rdy = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL beat_valid cyc %0d: out_valid=%b want 1 (%0d beats pending)", cyc, out_valid, exp_q.size());
        exp_q.delete();
        break;
      end
      o.hit = out_hit; o.onehot = out_onehot; o.idx = out_index;
      o.last = out_last; o.trunc = out_trunc; o.cnt = out_count;
      e = exp_q[0];
      if (o !== e) begin
        errors++;
        $display("FAIL beat cyc %0d: got hit=%b idx=%0d last=%b trunc=%b cnt=%0d oh=%h want hit=%b idx=%0d last=%b trunc=%b cnt=%0d oh=%h",
                 cyc, o.hit, o.idx, o.last, o.trunc, o.cnt, o.onehot, e.hit, e.idx, e.last, e.trunc, e.cnt, e.onehot);
      end
      if (rdy) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_budget: %0d beats still expected, want 0", exp_q.size());
      exp_q.delete();
    end else if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_last: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] v;
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_hit !== 1'b0 || out_onehot !== '0 ||
        out_index !== '0 || out_last !== 1'b0 || out_trunc !== 1'b0 || out_count !== 9'd1) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b hit=%b idx=%0d last=%b trunc=%b cnt=%0d want 0 0 0 0 0 0 1",
               in_ready, out_valid, out_hit, out_index, out_last, out_trunc, out_count);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    // Mid-scan reset with three beats still pending.
    v = '0; v[40] = 1'b1; v[30] = 1'b1; v[20] = 1'b1; v[10] = 1'b1;
    send(v, 1'b0, 9'd0);
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 8'd40) begin
      errors++;
      $display("FAIL reset_first_beat: valid=%b idx=%0d want 1 40", out_valid, out_index);
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_stale %0d: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_msb_drain();
    logic [N-1:0] v;
    v = '0; v[255] = 1'b1; v[130] = 1'b1; v[17] = 1'b1; v[0] = 1'b1;
    send(v, 1'b0, 9'd0);
    drain(0);
  endtask

  task automatic test_lsb_backpressure();
    logic [N-1:0] v;
    v = '0; v[3] = 1'b1; v[64] = 1'b1; v[200] = 1'b1;
    send(v, 1'b1, 9'd0);
    drain(1);
  endtask

  task automatic test_limit_trunc();
    send({N{1'b1}}, 1'b0, 9'd2);
    drain(0);
  endtask

  task automatic test_empty();
    send('0, 1'b0, 9'd0);
    drain(0);
  endtask

  task automatic test_full_drain();
    send({N{1'b1}}, 1'b1, 9'd256);
    drain(0);
  endtask

  task automatic test_back_to_back_random();
    logic [N-1:0] v;
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom() & $urandom();
      if (r == 3) v = '0;
      send(v, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 80)));
      drain(2);
    end
  endtask

  initial begin
    test_reset();
    test_msb_drain();
    test_lsb_backpressure();
    test_limit_trunc();
    test_empty();
    test_full_drain();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
